el2_gf_mulred: RTL and testbench
================================

# el2_gf_mulred

Parametrised iterative GF(2^WIDTH) multiply-and-reduce unit with a runtime-programmable reduction polynomial and a valid/ready handshake. It generalises the fixed 12-bit, fixed-polynomial (x^12+x^3+1) combinational reducer in the EXU. It computes a·b mod p(x) over DIGIT bits per cycle. It sits beside the EXU carry-less datapath as a multi-cycle functional unit.

## Interface
- WIDTH, 12: field degree m; operands, polynomial and result are WIDTH bits; WIDTH >= 2.
- DIGIT, 1: multiplier bits consumed per cycle; must divide WIDTH; an illegal value is an elaboration error.
- clk  in  1  clock; all state updates on its rising edge.
- rst_l  in  1  reset; one clock; reset is synchronous and active-low.
- in_valid  in  1  operand set valid.
- in_ready  out  1  unit can accept operands; high only in IDLE.
- in_a  in  WIDTH  multiplicand a(x).
- in_b  in  WIDTH  multiplier b(x).
- in_poly  in  WIDTH  low WIDTH coefficients of p(x); x^WIDTH term implicit.
- in_mac  in  1  accumulate request (see Configuration).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  WIDTH  a·b mod p(x) (or its accumulated form).
- busy  out  1  high in BUSY or DONE.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: in_ready=1. When in_valid&in_ready are high at a rising edge:
  - capture a, b, poly and mac into internal registers;
  - clear the accumulator;
  - load the digit counter with WIDTH/DIGIT;
  - go to BUSY.
- Inputs need not be held after acceptance.
- BUSY: each edge performs DIGIT MSB-first steps on b. Each step:
  - t = acc<<1 truncated to WIDTH bits, XOR poly if acc[WIDTH-1] was 1;
  - acc = t XOR (b_bit ? a : 0).
- BUSY: after the counter reaches zero, go to DONE.
- DONE: out_valid=1 and out_data is the final value. out_data is stable while out_valid&!out_ready. On out_ready, go to IDLE.
- out_data holds its last value in IDLE. It changes only on the BUSY->DONE edge.
- Arithmetic is pure XOR/shift (carry-less). There is no overflow.
- poly=0 is legal and gives a·b mod x^WIDTH.
- in_valid is ignored outside IDLE. out_ready is ignored outside DONE.
- Reset mid-operation, from any state, with rst_l low at an edge:
  - state goes to IDLE; the in-flight operation is discarded;
  - acc, out_data and the last-result register clear to 0.

## Timing
- Reset values: in_ready=1 (IDLE), out_valid=0, out_data=0, busy=0.
- Let N = WIDTH/DIGIT and acceptance be edge E0.
- Iteration edges are E1..EN. out_valid rises after EN, so the latency is N cycles (12 at defaults).
- Earliest next acceptance is the edge after the out handshake. The minimum initiation interval is N+2 cycles.
- in_ready, out_valid and busy are decoded from registered state only. There is no combinational path from any input to any output.
- A single step's critical path is one shift plus two XOR levels. With DIGIT>1 it is DIGIT steps chained combinationally.

## Configuration
- GF_MAC_EN defined:
  - the unit keeps a last-result register, updated at each out handshake;
  - when mac is captured as 1, out_data = (a·b mod p) XOR last-result;
  - when mac is 0, out_data = a·b mod p.
- GF_MAC_EN undefined:
  - in_mac is ignored and the last-result register is not built;
  - out_data is always a·b mod p.

## Test plan
- Reset: hold rst_l=0 for 2 edges, release. Expect in_ready=1, out_valid=0, out_data=0x000, busy=0.
- WIDTH=12, DIGIT=1, poly=0x009, a=0x800, b=0x002: expect out_data=0x009, with out_valid exactly 12 cycles after acceptance. Also a=0x800, b=0x800 gives 0x412; a=0x001, b=0xABC gives 0xABC.
- Backpressure: hold out_ready=0 for 5 cycles in DONE. Expect out_data stable, in_ready=0, and an in_valid pulse ignored. Then out_ready=1 gives IDLE on the next edge.
- Reset mid-operation: assert rst_l=0 at cycle 6 of BUSY. Expect IDLE and out_valid=0. A new op with a=0x003, b=0x003, poly=0x009 gives 0x005.
- DIGIT=4, same vectors as the WIDTH=12 case: identical results with latency 3 cycles.
- GF_MAC_EN: first op (0x800, 0x002, mac=0) gives 0x009. Next op (0x001, 0x00F, mac=1) gives 0x006. Without the macro the second op gives 0x00F.

Source files
------------

// File: rtl/el2_gf_mulred.sv
// el2_gf_mulred
//   Iterative GF(2^WIDTH) multiply-and-reduce unit. Computes a(x)*b(x) mod p(x)
//   by consuming DIGIT multiplier bits (MSB first) per clock, with the reduction
//   polynomial p(x) supplied per operation (x^WIDTH term implicit).
//
// Parameters
//   WIDTH : field degree m (>= 2)
//   DIGIT : multiplier bits per cycle; must divide WIDTH
//
// Optional feature
//   GF_MAC_EN : when defined, keeps a last-result register and, for operations
//               captured with in_mac=1, returns (a*b mod p) XOR last-result.
//
// Ports
//   clk, rst_l             : clock, synchronous active-low reset
//   in_valid/in_ready      : operand handshake (ready only in IDLE)
//   in_a, in_b, in_poly    : multiplicand, multiplier, low poly coefficients
//   in_mac                 : accumulate request (used only with GF_MAC_EN)
//   out_valid/out_ready    : result handshake (valid only in DONE)
//   out_data               : result, held until the next BUSY->DONE edge
//   busy                   : high in BUSY or DONE
module el2_gf_mulred #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_poly,
  input  logic             in_mac,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  localparam int unsigned DIG_SAFE = (DIGIT < 1) ? 1 : DIGIT;
  localparam int unsigned N        = WIDTH / DIG_SAFE;
  localparam int unsigned CW       = $clog2(N + 1);

  if ((WIDTH < 2) || (DIGIT < 1) || ((WIDTH % DIG_SAFE) != 0)) begin : g_param_err
    $error("el2_gf_mulred: WIDTH must be >= 2 and DIGIT must divide WIDTH");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] poly_q, poly_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_step;
  logic [WIDTH-1:0] result;

`ifdef GF_MAC_EN
  logic             mac_q, mac_d;
  logic [WIDTH-1:0] last_q, last_d;
`else
  logic             unused_in_mac;
  assign unused_in_mac = in_mac;
`endif

  // DIGIT chained MSB-first shift/reduce/add steps; b_q is kept left-aligned
  // so the current digit always sits in its top bits.
  always_comb begin
    acc_step = acc_q;
    for (int unsigned i = 0; i < DIGIT; i++) begin
      acc_step = {acc_step[WIDTH-2:0], 1'b0}
               ^ (acc_step[WIDTH-1] ? poly_q : '0)
               ^ (b_q[WIDTH-1-i] ? a_q : '0);
    end
  end

`ifdef GF_MAC_EN
  assign result = acc_step ^ (mac_q ? last_q : '0);
`else
  assign result = acc_step;
`endif

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    poly_d     = poly_q;
    acc_d      = acc_q;
    out_data_d = out_data_q;
    cnt_d      = cnt_q;
`ifdef GF_MAC_EN
    mac_d      = mac_q;
    last_d     = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          poly_d  = in_poly;
          acc_d   = '0;
          cnt_d   = CW'(N);
          state_d = BUSY;
`ifdef GF_MAC_EN
          mac_d   = in_mac;
`endif
        end
      end
      BUSY: begin
        acc_d = acc_step;
        b_d   = b_q << DIGIT;
        cnt_d = cnt_q - 1'b1;
        // Last digit: publish the result on the same edge the counter hits 0.
        if (cnt_q == CW'(1)) begin
          out_data_d = result;
          state_d    = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
`ifdef GF_MAC_EN
          last_d  = out_data_q;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      poly_q     <= '0;
      acc_q      <= '0;
      out_data_q <= '0;
      cnt_q      <= '0;
`ifdef GF_MAC_EN
      mac_q      <= 1'b0;
      last_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      poly_q     <= poly_d;
      acc_q      <= acc_d;
      out_data_q <= out_data_d;
      cnt_q      <= cnt_d;
`ifdef GF_MAC_EN
      mac_q      <= mac_d;
      last_q     <= last_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == BUSY) || (state_q == DONE);
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_el2_gf_mulred.sv
// Testbench for el2_gf_mulred: a DIGIT=1 and a DIGIT=4 instance share the
// same stimulus; results are compared with a polynomial long-division model.
module tb_el2_gf_mulred;

  localparam int unsigned W = 12;

  logic         clk = 1'b0;
  logic         rst_l;
  logic         in_valid;
  logic [W-1:0] in_a, in_b, in_poly;
  logic         in_mac;
  logic         out_ready;

  logic         rdy1, val1, busy1;
  logic [W-1:0] data1;
  logic         rdy4, val4, busy4;
  logic [W-1:0] data4;

  int tests = 0;
  int fails = 0;
  logic [W-1:0] model_last = '0;

  always #5 clk = ~clk;

  el2_gf_mulred #(.WIDTH(W), .DIGIT(1)) dut1 (
    .clk(clk), .rst_l(rst_l), .in_valid(in_valid), .in_ready(rdy1),
    .in_a(in_a), .in_b(in_b), .in_poly(in_poly), .in_mac(in_mac),
    .out_valid(val1), .out_ready(out_ready), .out_data(data1), .busy(busy1)
  );

  el2_gf_mulred #(.WIDTH(W), .DIGIT(4)) dut4 (
    .clk(clk), .rst_l(rst_l), .in_valid(in_valid), .in_ready(rdy4),
    .in_a(in_a), .in_b(in_b), .in_poly(in_poly), .in_mac(in_mac),
    .out_valid(val4), .out_ready(out_ready), .out_data(data4), .busy(busy4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full carry-less product, then long division by x^W + poly.
  function automatic logic [W-1:0] ref_mulmod(input logic [W-1:0] a,
                                              input logic [W-1:0] b,
                                              input logic [W-1:0] p);
    logic [2*W-1:0] prod;
    logic [2*W-1:0] divisor;
    prod = '0;
    for (int i = 0; i < W; i++)
      if (b[i]) prod = prod ^ ((2*W)'(a) << i);
    for (int k = 2*W-2; k >= W; k--) begin
      divisor = (2*W)'({1'b1, p});
      if (prod[k]) prod = prod ^ (divisor << (k - W));
    end
    return prod[W-1:0];
  endfunction

  function automatic logic [W-1:0] ref_expect(input logic [W-1:0] a,
                                              input logic [W-1:0] b,
                                              input logic [W-1:0] p,
                                              input logic mac);
    logic [W-1:0] r;
    r = ref_mulmod(a, b, p);
`ifdef GF_MAC_EN
    if (mac) r = r ^ model_last;
`else
    if (mac) r = r;
`endif
    return r;
  endfunction

  // One full transaction on both instances, checking latency, hold behaviour
  // while busy, the result and the return to IDLE.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] p, input logic mac,
                       input logic [W-1:0] exp, input string name);
    logic [W-1:0] prev1, prev4;
    int lat1, lat4;
    prev1 = data1;
    prev4 = data4;
    in_a = a; in_b = b; in_poly = p; in_mac = mac; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_a = W'($urandom); in_b = W'($urandom); in_poly = W'($urandom); in_mac = 1'($urandom);
    tests++;
    if ({busy1, busy4, rdy1, rdy4} !== 4'b1100) begin
      fails++;
      $display("FAIL %s accept: busy1/busy4/rdy1/rdy4=%b required 1100", name, {busy1, busy4, rdy1, rdy4});
    end
    lat1 = 0;
    lat4 = 0;
    for (int c = 1; c <= 40 && (lat1 == 0 || lat4 == 0); c++) begin
      tick();
      if (lat1 == 0) begin
        if (val1) lat1 = c;
        else begin
          tests++;
          if (data1 !== prev1) begin
            fails++;
            $display("FAIL %s hold1 cycle %0d: out_data=%h required %h", name, c, data1, prev1);
          end
        end
      end
      if (lat4 == 0) begin
        if (val4) lat4 = c;
        else begin
          tests++;
          if (data4 !== prev4) begin
            fails++;
            $display("FAIL %s hold4 cycle %0d: out_data=%h required %h", name, c, data4, prev4);
          end
        end
      end
    end
    tests++;
    if (lat1 != 12) begin
      fails++;
      $display("FAIL %s latency1: got %0d required 12 (0 = timeout)", name, lat1);
    end
    tests++;
    if (lat4 != 3) begin
      fails++;
      $display("FAIL %s latency4: got %0d required 3 (0 = timeout)", name, lat4);
    end
    tests++;
    if (data1 !== exp) begin
      fails++;
      $display("FAIL %s data1: got %h required %h", name, data1, exp);
    end
    tests++;
    if (data4 !== exp) begin
      fails++;
      $display("FAIL %s data4: got %h required %h", name, data4, exp);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    model_last = exp;
    tests++;
    if ({rdy1, rdy4, val1, val4, busy1, busy4} !== 6'b110000 || data1 !== exp || data4 !== exp) begin
      fails++;
      $display("FAIL %s release: rdy/val/busy=%b required 110000, data1=%h data4=%h required %h",
               name, {rdy1, rdy4, val1, val4, busy1, busy4}, data1, data4, exp);
    end
  endtask

  task automatic test_reset();
    rst_l = 1'b0;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_poly = '0; in_mac = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    rst_l = 1'b1;
    model_last = '0;
    tests++;
    if ({rdy1, val1, busy1} !== 3'b100 || data1 !== 12'h000) begin
      fails++;
      $display("FAIL reset1: rdy/val/busy=%b data=%h required 100 and 000", {rdy1, val1, busy1}, data1);
    end
    tests++;
    if ({rdy4, val4, busy4} !== 3'b100 || data4 !== 12'h000) begin
      fails++;
      $display("FAIL reset4: rdy/val/busy=%b data=%h required 100 and 000", {rdy4, val4, busy4}, data4);
    end
  endtask

  task automatic test_vectors();
    do_op(12'h800, 12'h002, 12'h009, 1'b0, 12'h009, "vec_x12");
    do_op(12'h800, 12'h800, 12'h009, 1'b0, 12'h412, "vec_x22");
    do_op(12'h001, 12'hABC, 12'h009, 1'b0, 12'hABC, "vec_one");
    do_op(12'hFFF, 12'hFFF, 12'h000, 1'b0, ref_expect(12'hFFF, 12'hFFF, 12'h000, 1'b0), "vec_poly0");
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, p;
    logic m;
    for (int i = 0; i < 20; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      p = W'($urandom);
      m = 1'($urandom);
      do_op(a, b, p, m, ref_expect(a, b, p, m), "random");
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] exp;
    exp = ref_expect(12'h5A5, 12'h3C3, 12'h053, 1'b0);
    in_a = 12'h5A5; in_b = 12'h3C3; in_poly = 12'h053; in_mac = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 40 && !(val1 && val4); c++) tick();
    tests++;
    if (!(val1 && val4)) begin
      fails++;
      $display("FAIL bp_wait: out_valid1/4=%b%b required 11", val1, val4);
    end
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin
        in_a = 12'h001; in_b = 12'h001; in_poly = 12'h000; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      tests++;
      if (data1 !== exp || data4 !== exp || {rdy1, rdy4, val1, val4} !== 4'b0011) begin
        fails++;
        $display("FAIL bp_hold cycle %0d: data1=%h data4=%h rdy/val=%b required %h and 0011",
                 c, data1, data4, {rdy1, rdy4, val1, val4}, exp);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    model_last = exp;
    tests++;
    if ({rdy1, rdy4, val1, val4} !== 4'b1100) begin
      fails++;
      $display("FAIL bp_release: rdy/val=%b required 1100", {rdy1, rdy4, val1, val4});
    end
    tick();
    tests++;
    if ({busy1, busy4, rdy1, rdy4} !== 4'b0011 || data1 !== exp) begin
      fails++;
      $display("FAIL bp_ignored: busy/rdy=%b data1=%h required 0011 and %h", {busy1, busy4, rdy1, rdy4}, data1, exp);
    end
  endtask

  task automatic test_reset_mid();
    in_a = 12'h7E1; in_b = 12'hB0D; in_poly = 12'h009; in_mac = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 6; c++) tick();
    rst_l = 1'b0;
    tick();
    rst_l = 1'b1;
    model_last = '0;
    tests++;
    if ({rdy1, val1, busy1} !== 3'b100 || data1 !== 12'h000) begin
      fails++;
      $display("FAIL midreset1: rdy/val/busy=%b data=%h required 100 and 000", {rdy1, val1, busy1}, data1);
    end
    tests++;
    if ({rdy4, val4, busy4} !== 3'b100 || data4 !== 12'h000) begin
      fails++;
      $display("FAIL midreset4: rdy/val/busy=%b data=%h required 100 and 000", {rdy4, val4, busy4}, data4);
    end
    do_op(12'h003, 12'h003, 12'h009, 1'b0, 12'h005, "after_reset");
  endtask

  task automatic test_mac();
    do_op(12'h800, 12'h002, 12'h009, 1'b0, 12'h009, "mac_first");
`ifdef GF_MAC_EN
    do_op(12'h001, 12'h00F, 12'h009, 1'b1, 12'h006, "mac_second");
`else
    do_op(12'h001, 12'h00F, 12'h009, 1'b1, 12'h00F, "mac_second");
`endif
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_mid();
    test_mac();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
